timer_regfile_mc: RTL and testbench
===================================

# timer_regfile_mc

Parametrised multi-channel register file for the timer IP. It sits between the APB slave front-end and the counter, counter-control, interrupt and halt logic. It holds control, counter data, NCH compare registers with per-channel sticky interrupt status, and halt control. It adds an unmapped-address error, channel-wide W1C status and an optional coherent 64-bit counter read.

## Interface
- CNT_W, 64, counter width; legal 33..64.
- NCH, 4, number of compare channels; legal 1..8.
- MAX_DIV, 8, largest legal div_val.
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- wr_en / rd_en  in  1  APB register write / read qualifier, single cycle.
- addr  in  12  byte address.
- wdata  in  32  write data.
- strb  in  4  byte strobes.
- rdata  out  32  read data, combinational.
- error_res  out  1  access error, combinational, same cycle as wr_en/rd_en.
- cnt  in  CNT_W  live counter value.
- load_back  in  1  copy cnt into TDR.
- cnt_clr  out  1  one-cycle counter clear pulse.
- tdr_wr_en  out  1  one-cycle counter load pulse.
- TDR_wr  out  CNT_W  counter load value.
- timer_en, div_en  out  1  TCR[0], TCR[1].
- div_val  out  4  TCR[11:8].
- TCMP  out  NCH*CNT_W  compare values; channel i at [i*CNT_W +: CNT_W].
- cmp_match  in  NCH  per-channel one-cycle match pulses.
- int_en  out  NCH  TIER[NCH-1:0].
- irq  out  1  OR of (TISR & TIER).
- halt_req  out  1  THCSR[0].
- halt_ack  in  1  halt acknowledge.

## Operation
- Address map:
  - 0x00 TCR; 0x04 TDR0 (cnt[31:0]); 0x08 TDR1 (cnt[CNT_W-1:32]).
  - 0x0C TIER; 0x10 TISR; 0x14 THCSR.
  - 0x20+8i TCMPi_lo; 0x24+8i TCMPi_hi, for i<NCH.
- Any other address with wr_en or rd_en: error_res=1. The read returns 0 and a write has no effect.
- TCR write:
  - error_res=1 if strb[1] and wdata[11:8]>MAX_DIV.
  - error_res=1 if TCR[0]=1 and the write changes div_en (strb[0]) or div_val (strb[1]).
  - On error, no field updates. Otherwise strb[0] updates bits 1:0 and strb[1] updates bits 11:8.
  - A strb[0] write taking timer_en from 1 to 0 pulses cnt_clr next cycle, even when error_res=1.
  - Reserved bits read 0.
- TDR writes are byte-strobe merged.
  - Next cycle: tdr_wr_en=1 and TDR_wr holds the merged value with the other half unchanged.
  - A TDR write has priority over load_back in the same cycle.
  - Otherwise load_back copies cnt into TDR0/TDR1.
- TCMP writes are byte-strobe merged.
- TDR1 and TCMPi_hi bits at or above CNT_W-32: writes ignored, reads 0.
- TIER: strb[0] writes bits NCH-1:0; other bits read 0.
- TISR:
  - Bit i sets on cmp_match[i].
  - Writing 1 with strb[0] clears bit i.
  - If set and clear hit the same cycle, set wins.
- THCSR: bit0 is halt_req (R/W, strb[0]); bit1 is a registered copy of halt_ack (RO).
- rdata is 0 when rd_en=0.

## Timing
- Reset values:
  - TCR=0x0000_0100; TDR=0; TCMPi=all ones (CNT_W bits); TIER=TISR=THCSR=0.
  - cnt_clr=tdr_wr_en=0; TDR_wr=0; irq=0.
- Register updates land on the sys_clk edge ending the wr_en cycle.
- Pulse outputs (cnt_clr, tdr_wr_en) are high for exactly one cycle following that edge.
- Latency from cmp_match to TISR bit to irq is one cycle; irq is combinational from flops.
- halt_ack reaches THCSR[1] with one cycle of latency.
- Asserting reset mid-operation clears all state immediately, including any pending pulses.

## Configuration
- TIMER_RF_SNAPSHOT_EN defined:
  - A TDR0 read (rd_en, no error) captures TDR1 into a snapshot register and sets snap_valid on the next edge.
  - A TDR1 read returns the snapshot while snap_valid=1, then clears snap_valid.
  - Any TDR write or reset clears snap_valid.
- TIMER_RF_SNAPSHOT_EN undefined: TDR1 reads return the live TDR1; no snapshot flops are built.

## Structure
- Shared package timer_rf_pkg holds:
  - address constants (ADDR_TCR … ADDR_TCMP_BASE, TCMP stride 8);
  - TCR field positions;
  - reset constants;
  - default MAX_DIV.
- Sub-module timer_rf_chan holds one channel's TCMP register, strobe merge and sticky status bit with set-priority. It is generate-instantiated NCH times.

## Test plan
- Reset release: TCR read=0x100, TCMP0_lo=0xFFFF_FFFF, TISR=0, irq=0; read of 0x40 with NCH=4 gives error_res=1 and rdata=0.
- TCR write 0x0000_0901 gives error_res=1 and TCR unchanged. Write 0x0000_0303, then 0x0000_0203: error_res=1 on the second, and div_val stays 3.
- timer_en 1 to 0 via wdata=0x0000_0302 with strb=0x1: cnt_clr high for one cycle, TCR=0x0000_0302.
- TDR0 write 0x1234_5678 with strb=0x3 while load_back=1, TDR0 was 0: TDR0=0x0000_5678, tdr_wr_en pulses once, TDR_wr[31:0]=0x0000_5678.
- cmp_match[2] pulse with TIER=0x4: TISR=0x4 and irq=1 after one cycle. W1C 0x4 in the same cycle as a new cmp_match[2]: TISR stays 0x4. A later W1C alone gives TISR=0 and irq=0.
- With TIMER_RF_SNAPSHOT_EN, load_back cnt=0x1_FFFF_FFFF, then read TDR0 (0xFFFF_FFFF). Then load_back cnt=0x2_0000_0000 and read TDR1: it returns 0x1. A second TDR1 read returns 0x2.

Source files
------------

// File: rtl/timer_rf_pkg.sv
// -----------------------------------------------------------------------------
// timer_rf_pkg
// Shared definitions for the timer register file: register address map,
// TCR field positions, reset constants, default MAX_DIV, the register-select
// enum used by the address decoder, and a byte-strobe merge helper.
// -----------------------------------------------------------------------------
package timer_rf_pkg;

   // Register address map (byte addresses)
   localparam logic [11:0] ADDR_TCR       = 12'h000;
   localparam logic [11:0] ADDR_TDR0      = 12'h004;
   localparam logic [11:0] ADDR_TDR1      = 12'h008;
   localparam logic [11:0] ADDR_TIER      = 12'h00C;
   localparam logic [11:0] ADDR_TISR      = 12'h010;
   localparam logic [11:0] ADDR_THCSR     = 12'h014;
   localparam logic [11:0] ADDR_TCMP_BASE = 12'h020;
   localparam int          TCMP_STRIDE    = 8;

   // TCR field positions
   localparam int TCR_TIMER_EN_BIT = 0;
   localparam int TCR_DIV_EN_BIT   = 1;
   localparam int TCR_DIV_VAL_LSB  = 8;
   localparam int TCR_DIV_VAL_MSB  = 11;

   // Reset constants
   localparam logic [31:0] TCR_RST     = 32'h0000_0100;
   localparam logic [3:0]  DIV_VAL_RST = 4'h1;

   localparam int DEFAULT_MAX_DIV = 8;

   // One-hot-free register select produced by the address decoder
   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_TCR,
      SEL_TDR0,
      SEL_TDR1,
      SEL_TIER,
      SEL_TISR,
      SEL_THCSR,
      SEL_TCMP
   } reg_sel_e;

   // Replace each byte of old_v whose strobe is set with the matching byte of new_v
   function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_v;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/timer_regfile_mc_if.sv
// -----------------------------------------------------------------------------
// timer_regfile_mc_if
// Register-access bus between the APB slave front-end (master) and the timer
// register file (slave).
//   wr_en, rd_en : single-cycle write / read qualifiers
//   addr         : 12-bit byte address
//   wdata, strb  : write data and byte strobes
//   rdata        : combinational read data (0 when rd_en=0)
//   error_res    : combinational access error, same cycle as wr_en/rd_en
// -----------------------------------------------------------------------------
interface timer_regfile_mc_if;
   logic        wr_en;
   logic        rd_en;
   logic [11:0] addr;
   logic [31:0] wdata;
   logic [3:0]  strb;
   logic [31:0] rdata;
   logic        error_res;

   modport master (
      output wr_en, rd_en, addr, wdata, strb,
      input  rdata, error_res
   );

   modport slave (
      input  wr_en, rd_en, addr, wdata, strb,
      output rdata, error_res
   );
endinterface

// File: rtl/timer_rf_chan.sv
// -----------------------------------------------------------------------------
// timer_rf_chan
// One compare channel: CNT_W-bit TCMP register written as a lo word and a
// (CNT_W-32)-bit hi word with byte-strobe merge, plus the sticky interrupt
// status bit (set by cmp_match, cleared by W1C, set wins).
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   wr_lo, wr_hi       : decoded write strobes for TCMPi_lo / TCMPi_hi
//   wdata, strb        : bus write data and byte strobes
//   set                : cmp_match pulse for this channel
//   clr                : W1C request for this channel's status bit
//   tcmp               : compare value
//   status             : sticky interrupt status
// -----------------------------------------------------------------------------
module timer_rf_chan
   import timer_rf_pkg::*;
#(
   parameter int CNT_W = 64
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             wr_lo,
   input  logic             wr_hi,
   input  logic [31:0]      wdata,
   input  logic [3:0]       strb,
   input  logic             set,
   input  logic             clr,
   output logic [CNT_W-1:0] tcmp,
   output logic             status
);

   localparam int HI_W = CNT_W - 32;

   logic [CNT_W-1:0] tcmp_q, tcmp_d;
   logic             status_q, status_d;
   logic [31:0]      lo_merged;
   logic [31:0]      hi_merged;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      tcmp_d    = tcmp_q;
      lo_merged = strb_merge(tcmp_q[31:0], wdata, strb);
      // Hi word is zero-extended before merging; bits at or above HI_W are dropped.
      hi_merged = strb_merge(32'(tcmp_q[CNT_W-1:32]), wdata, strb);
      if (wr_lo) tcmp_d[31:0]       = lo_merged;
      if (wr_hi) tcmp_d[CNT_W-1:32] = hi_merged[HI_W-1:0];
   end

   // Set has priority over a simultaneous clear so no match is lost.
   assign status_d = set | (status_q & ~clr);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         // NOTE: compare registers reset to all ones so no spurious match fires before software programs them.
         tcmp_q   <= '1;
         status_q <= 1'b0;
      end else begin
         // NOTE: state flops use non-blocking assignment so all registers update together on the edge.
         tcmp_q   <= tcmp_d;
         status_q <= status_d;
      end
   end

   assign tcmp   = tcmp_q;
   assign status = status_q;

endmodule

// File: rtl/timer_regfile_mc.sv
// -----------------------------------------------------------------------------
// timer_regfile_mc
// Multi-channel timer register file: TCR, TDR0/TDR1, TIER, TISR, THCSR and
// NCH compare channels, with unmapped-address error and channel-wide W1C.
// Optional feature macro: TIMER_RF_SNAPSHOT_EN -- a TDR0 read snapshots TDR1
// so a following TDR1 read returns a value coherent with the TDR0 read.
// Ports:
//   sys_clk, sys_rst_n   : clock, asynchronous active-low reset
//   bus                  : register access bus (slave modport)
//   cnt, load_back       : live counter and copy-into-TDR request
//   cnt_clr, tdr_wr_en   : one-cycle counter clear / load pulses
//   TDR_wr               : counter load value
//   timer_en, div_en     : TCR[0], TCR[1]
//   div_val              : TCR[11:8]
//   TCMP                 : compare values, channel i at [i*CNT_W +: CNT_W]
//   cmp_match            : per-channel match pulses
//   int_en, irq          : TIER and OR of (TISR & TIER)
//   halt_req, halt_ack   : halt request (THCSR[0]) and acknowledge
// -----------------------------------------------------------------------------
module timer_regfile_mc
   import timer_rf_pkg::*;
#(
   parameter int CNT_W   = 64,
   parameter int NCH     = 4,
   parameter int MAX_DIV = DEFAULT_MAX_DIV
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   timer_regfile_mc_if.slave    bus,
   input  logic [CNT_W-1:0]     cnt,
   input  logic                 load_back,
   output logic                 cnt_clr,
   output logic                 tdr_wr_en,
   output logic [CNT_W-1:0]     TDR_wr,
   output logic                 timer_en,
   output logic                 div_en,
   output logic [3:0]           div_val,
   output logic [NCH*CNT_W-1:0] TCMP,
   input  logic [NCH-1:0]       cmp_match,
   output logic [NCH-1:0]       int_en,
   output logic                 irq,
   output logic                 halt_req,
   input  logic                 halt_ack
);

   localparam int          HI_W      = CNT_W - 32;
   localparam logic [3:0]  MAX_DIV_V = 4'(MAX_DIV);

   // ---------------------------------------------------------------- decode
   reg_sel_e    sel;
   logic [11:0] tcmp_off;
   logic [8:0]  chan_idx;
   logic        tcmp_hi;

   assign tcmp_off = bus.addr - ADDR_TCMP_BASE;
   assign chan_idx = tcmp_off[11:3];
   assign tcmp_hi  = bus.addr[2];

   always_comb begin
      sel = SEL_NONE;
      case (bus.addr)
         ADDR_TCR:   sel = SEL_TCR;
         ADDR_TDR0:  sel = SEL_TDR0;
         ADDR_TDR1:  sel = SEL_TDR1;
         ADDR_TIER:  sel = SEL_TIER;
         ADDR_TISR:  sel = SEL_TISR;
         ADDR_THCSR: sel = SEL_THCSR;
         default: begin
            if (bus.addr >= ADDR_TCMP_BASE && bus.addr[1:0] == 2'b00 &&
                chan_idx < 9'(NCH))
               sel = SEL_TCMP;
         end
      endcase
   end

   logic wr_tcr, wr_tdr0, wr_tdr1, wr_tier, wr_tisr, wr_thcsr, wr_tcmp;
   logic rd_tdr0, rd_tdr1;

   assign wr_tcr   = bus.wr_en && sel == SEL_TCR;
   assign wr_tdr0  = bus.wr_en && sel == SEL_TDR0;
   assign wr_tdr1  = bus.wr_en && sel == SEL_TDR1;
   assign wr_tier  = bus.wr_en && sel == SEL_TIER;
   assign wr_tisr  = bus.wr_en && sel == SEL_TISR;
   assign wr_thcsr = bus.wr_en && sel == SEL_THCSR;
   assign wr_tcmp  = bus.wr_en && sel == SEL_TCMP;
   assign rd_tdr0  = bus.rd_en && sel == SEL_TDR0;
   assign rd_tdr1  = bus.rd_en && sel == SEL_TDR1;

   // ------------------------------------------------------------------- TCR
   logic       timer_en_q, timer_en_d;
   logic       div_en_q, div_en_d;
   logic [3:0] div_val_q, div_val_d;
   logic       tcr_err;
   logic       cnt_clr_q;

   // Divider settings are frozen while the timer runs; out-of-range div_val is rejected.
   assign tcr_err = wr_tcr &&
      ((bus.strb[1] && bus.wdata[TCR_DIV_VAL_MSB:TCR_DIV_VAL_LSB] > MAX_DIV_V) ||
       (timer_en_q &&
        ((bus.strb[0] && bus.wdata[TCR_DIV_EN_BIT] != div_en_q) ||
         (bus.strb[1] && bus.wdata[TCR_DIV_VAL_MSB:TCR_DIV_VAL_LSB] != div_val_q))));

   assign bus.error_res = (bus.wr_en || bus.rd_en) && (sel == SEL_NONE || tcr_err);

   always_comb begin
      timer_en_d = timer_en_q;
      div_en_d   = div_en_q;
      div_val_d  = div_val_q;
      if (wr_tcr && !tcr_err) begin
         if (bus.strb[0]) begin
            timer_en_d = bus.wdata[TCR_TIMER_EN_BIT];
            div_en_d   = bus.wdata[TCR_DIV_EN_BIT];
         end
         if (bus.strb[1]) div_val_d = bus.wdata[TCR_DIV_VAL_MSB:TCR_DIV_VAL_LSB];
      end
   end

   // ------------------------------------------------------------------- TDR
   logic [31:0]      tdr0_q, tdr0_d;
   logic [HI_W-1:0]  tdr1_q, tdr1_d;
   logic [31:0]      tdr0_merged, tdr1_merged;
   logic [CNT_W-1:0] tdr_wr_q;
   logic             tdr_wr_en_q;
   logic [HI_W-1:0]  tdr1_rd;

   assign tdr0_merged = strb_merge(tdr0_q, bus.wdata, bus.strb);
   assign tdr1_merged = strb_merge(32'(tdr1_q), bus.wdata, bus.strb);

   // A bus write to either half blocks load_back for the whole cycle.
   always_comb begin
      tdr0_d = tdr0_q;
      tdr1_d = tdr1_q;
      if (wr_tdr0)        tdr0_d = tdr0_merged;
      else if (wr_tdr1)   tdr1_d = tdr1_merged[HI_W-1:0];
      else if (load_back) {tdr1_d, tdr0_d} = cnt;
   end

   // ---------------------------------------------------- TIER / TISR / THCSR
   logic [NCH-1:0] int_en_q;
   logic [NCH-1:0] tisr;
   logic           halt_req_q, halt_ack_q;

   // ---------------------------------------------------------------- flops
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         timer_en_q  <= TCR_RST[TCR_TIMER_EN_BIT];
         div_en_q    <= TCR_RST[TCR_DIV_EN_BIT];
         div_val_q   <= DIV_VAL_RST;
         cnt_clr_q   <= 1'b0;
         tdr0_q      <= '0;
         tdr1_q      <= '0;
         tdr_wr_q    <= '0;
         tdr_wr_en_q <= 1'b0;
         int_en_q    <= '0;
         halt_req_q  <= 1'b0;
         halt_ack_q  <= 1'b0;
      end else begin
         timer_en_q  <= timer_en_d;
         div_en_q    <= div_en_d;
         div_val_q   <= div_val_d;
         // Falling timer_en clears the counter even if the rest of the write errored.
         cnt_clr_q   <= wr_tcr && bus.strb[0] && timer_en_q && !bus.wdata[TCR_TIMER_EN_BIT];
         tdr0_q      <= tdr0_d;
         tdr1_q      <= tdr1_d;
         tdr_wr_en_q <= wr_tdr0 || wr_tdr1;
         if (wr_tdr0 || wr_tdr1) tdr_wr_q <= {tdr1_d, tdr0_d};
         if (wr_tier && bus.strb[0]) int_en_q <= bus.wdata[NCH-1:0];
         if (wr_thcsr && bus.strb[0]) halt_req_q <= bus.wdata[0];
         halt_ack_q  <= halt_ack;
      end
   end

   // -------------------------------------------------------- TDR1 snapshot
`ifdef TIMER_RF_SNAPSHOT_EN
   logic [HI_W-1:0] snap_q;
   logic            snap_valid_q;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         snap_q       <= '0;
         snap_valid_q <= 1'b0;
      end else if (wr_tdr0 || wr_tdr1) begin
         snap_valid_q <= 1'b0;
      end else if (rd_tdr0) begin
         snap_q       <= tdr1_q;
         snap_valid_q <= 1'b1;
      end else if (rd_tdr1) begin
         snap_valid_q <= 1'b0;
      end
   end

   assign tdr1_rd = snap_valid_q ? snap_q : tdr1_q;
`else
   assign tdr1_rd = tdr1_q;
`endif

   // -------------------------------------------------------------- channels
   for (genvar i = 0; i < NCH; i++) begin : g_chan
      timer_rf_chan #(.CNT_W(CNT_W)) u_chan (
         .sys_clk   (sys_clk),
         .sys_rst_n (sys_rst_n),
         .wr_lo     (wr_tcmp && chan_idx == 9'(i) && !tcmp_hi),
         .wr_hi     (wr_tcmp && chan_idx == 9'(i) && tcmp_hi),
         .wdata     (bus.wdata),
         .strb      (bus.strb),
         .set       (cmp_match[i]),
         .clr       (wr_tisr && bus.strb[0] && bus.wdata[i]),
         .tcmp      (TCMP[i*CNT_W +: CNT_W]),
         .status    (tisr[i])
      );
   end

   // ------------------------------------------------------------- read mux
   always_comb begin
      bus.rdata = '0;
      if (bus.rd_en) begin
         case (sel)
            SEL_TCR:   bus.rdata = {20'b0, div_val_q, 6'b0, div_en_q, timer_en_q};
            SEL_TDR0:  bus.rdata = tdr0_q;
            SEL_TDR1:  bus.rdata = 32'(tdr1_rd);
            SEL_TIER:  bus.rdata = 32'(int_en_q);
            SEL_TISR:  bus.rdata = 32'(tisr);
            SEL_THCSR: bus.rdata = {30'b0, halt_ack_q, halt_req_q};
            SEL_TCMP: begin
               for (int i = 0; i < NCH; i++) begin
                  if (chan_idx == 9'(i))
                     bus.rdata = tcmp_hi ? 32'(TCMP[i*CNT_W+32 +: HI_W])
                                         : TCMP[i*CNT_W +: 32];
               end
            end
            default:   bus.rdata = '0;
         endcase
      end
   end

   // --------------------------------------------------------------- outputs
   assign timer_en  = timer_en_q;
   assign div_en    = div_en_q;
   assign div_val   = div_val_q;
   assign cnt_clr   = cnt_clr_q;
   assign tdr_wr_en = tdr_wr_en_q;
   assign TDR_wr    = tdr_wr_q;
   assign int_en    = int_en_q;
   assign irq       = |(tisr & int_en_q);
   assign halt_req  = halt_req_q;

endmodule

// File: tb/tb_timer_regfile_mc.sv
// -----------------------------------------------------------------------------
// tb_timer_regfile_mc
// Directed self-checking bench for timer_regfile_mc (CNT_W=64, NCH=4).
// Inputs change just after the falling edge; combinational outputs are sampled
// 1 time unit later, registered outputs at the following falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_timer_regfile_mc;

   localparam int CNT_W = 64;
   localparam int NCH   = 4;

   logic                 sys_clk;
   logic                 sys_rst_n;
   logic [CNT_W-1:0]     cnt;
   logic                 load_back;
   logic                 cnt_clr;
   logic                 tdr_wr_en;
   logic [CNT_W-1:0]     TDR_wr;
   logic                 timer_en;
   logic                 div_en;
   logic [3:0]           div_val;
   logic [NCH*CNT_W-1:0] TCMP;
   logic [NCH-1:0]       cmp_match;
   logic [NCH-1:0]       int_en;
   logic                 irq;
   logic                 halt_req;
   logic                 halt_ack;

   timer_regfile_mc_if bus ();

   timer_regfile_mc #(.CNT_W(CNT_W), .NCH(NCH)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus),
      .cnt       (cnt),
      .load_back (load_back),
      .cnt_clr   (cnt_clr),
      .tdr_wr_en (tdr_wr_en),
      .TDR_wr    (TDR_wr),
      .timer_en  (timer_en),
      .div_en    (div_en),
      .div_val   (div_val),
      .TCMP      (TCMP),
      .cmp_match (cmp_match),
      .int_en    (int_en),
      .irq       (irq),
      .halt_req  (halt_req),
      .halt_ack  (halt_ack)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] last_rdata;
   logic        last_err;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Both tasks start just after a falling edge and return at the next one.
   task automatic bus_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
      bus.wr_en = 1'b1;
      bus.addr  = a;
      bus.wdata = d;
      bus.strb  = s;
      #1 last_err = bus.error_res;
      @(negedge sys_clk);
      bus.wr_en = 1'b0;
   endtask

   task automatic bus_read(input logic [11:0] a);
      bus.rd_en = 1'b1;
      bus.addr  = a;
      #1 begin
         last_rdata = bus.rdata;
         last_err   = bus.error_res;
      end
      @(negedge sys_clk);
      bus.rd_en = 1'b0;
   endtask

   initial begin
      sys_rst_n = 1'b0;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.addr  = '0;
      bus.wdata = '0;
      bus.strb  = '0;
      cnt       = '0;
      load_back = 1'b0;
      cmp_match = '0;
      halt_ack  = 1'b0;
      repeat (2) @(negedge sys_clk);

      // Reset state
      check("rst_irq",       64'(irq), 64'h0);
      check("rst_cnt_clr",   64'(cnt_clr), 64'h0);
      check("rst_tdr_wr_en", 64'(tdr_wr_en), 64'h0);
      check("rst_TDR_wr",    TDR_wr, 64'h0);
      check("rst_div_val",   64'(div_val), 64'h1);
      check("rst_tcmp3",     TCMP[3*CNT_W +: CNT_W], 64'hFFFF_FFFF_FFFF_FFFF);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);

      bus_read(12'h000);
      check("rd_tcr_rst", 64'(last_rdata), 64'h100);
      check("rd_tcr_err", 64'(last_err), 64'h0);
      bus_read(12'h020);
      check("rd_tcmp0_lo_rst", 64'(last_rdata), 64'hFFFF_FFFF);
      bus_read(12'h010);
      check("rd_tisr_rst", 64'(last_rdata), 64'h0);
      bus_read(12'h040);
      check("rd_unmapped_err",   64'(last_err), 64'h1);
      check("rd_unmapped_rdata", 64'(last_rdata), 64'h0);

      // TCR: div_val out of range, then a legal write, then a frozen-divider violation
      bus_write(12'h000, 32'h0000_0901, 4'hF);
      check("tcr_div9_err", 64'(last_err), 64'h1);
      bus_read(12'h000);
      check("tcr_div9_unchanged", 64'(last_rdata), 64'h100);
      bus_write(12'h000, 32'h0000_0303, 4'hF);
      check("tcr_303_err", 64'(last_err), 64'h0);
      check("tcr_303_fields", 64'({timer_en, div_en, div_val}), 64'h33);
      bus_write(12'h000, 32'h0000_0203, 4'hF);
      check("tcr_203_err", 64'(last_err), 64'h1);
      check("tcr_203_div_val", 64'(div_val), 64'h3);

      // timer_en 1 -> 0 pulses cnt_clr for exactly one cycle
      bus_write(12'h000, 32'h0000_0302, 4'h1);
      check("tcr_302_err", 64'(last_err), 64'h0);
      check("cnt_clr_pulse", 64'(cnt_clr), 64'h1);
      @(negedge sys_clk);
      check("cnt_clr_end", 64'(cnt_clr), 64'h0);
      bus_read(12'h000);
      check("tcr_302", 64'(last_rdata), 64'h302);

      // TDR0 write beats load_back in the same cycle
      cnt       = 64'hDEAD_BEEF_CAFE_F00D;
      load_back = 1'b1;
      bus_write(12'h004, 32'h1234_5678, 4'h3);
      load_back = 1'b0;
      check("tdr_wr_en_pulse", 64'(tdr_wr_en), 64'h1);
      check("TDR_wr_val", TDR_wr, 64'h0000_0000_0000_5678);
      @(negedge sys_clk);
      check("tdr_wr_en_end", 64'(tdr_wr_en), 64'h0);
      bus_read(12'h004);
      check("tdr0_merged", 64'(last_rdata), 64'h5678);
      bus_read(12'h008);
      check("tdr1_untouched", 64'(last_rdata), 64'h0);

      // Unmapped write
      bus_write(12'h018, 32'h44, 4'hF);
      check("wr_unmapped_err", 64'(last_err), 64'h1);

      // TCMP1_hi byte merge onto all-ones reset value
      bus_write(12'h02C, 32'hAABB_CCDD, 4'h5);
      check("tcmp1_out", TCMP[1*CNT_W +: CNT_W], 64'hFFBB_FFDD_FFFF_FFFF);
      bus_read(12'h02C);
      check("tcmp1_hi_rd", 64'(last_rdata), 64'hFFBB_FFDD);

      // Interrupt: set, set-beats-clear, clear
      bus_write(12'h00C, 32'h0000_0004, 4'h1);
      check("int_en", 64'(int_en), 64'h4);
      cmp_match = 4'b0100;
      @(negedge sys_clk);
      cmp_match = 4'b0000;
      check("irq_set", 64'(irq), 64'h1);
      bus_read(12'h010);
      check("tisr_set", 64'(last_rdata), 64'h4);
      cmp_match = 4'b0100;
      bus_write(12'h010, 32'h0000_0004, 4'h1);
      cmp_match = 4'b0000;
      bus_read(12'h010);
      check("tisr_set_wins", 64'(last_rdata), 64'h4);
      check("irq_set_wins", 64'(irq), 64'h1);
      bus_write(12'h010, 32'h0000_0004, 4'h1);
      bus_read(12'h010);
      check("tisr_cleared", 64'(last_rdata), 64'h0);
      check("irq_cleared", 64'(irq), 64'h0);

      // Halt control and one-cycle halt_ack latency
      bus_write(12'h014, 32'h0000_0001, 4'h1);
      check("halt_req", 64'(halt_req), 64'h1);
      halt_ack = 1'b1;
      bus_read(12'h014);
      check("thcsr_ack_lat", 64'(last_rdata), 64'h1);
      bus_read(12'h014);
      check("thcsr_ack", 64'(last_rdata), 64'h3);

      // Coherent 64-bit read
      cnt       = 64'h0000_0001_FFFF_FFFF;
      load_back = 1'b1;
      @(negedge sys_clk);
      load_back = 1'b0;
      bus_read(12'h004);
      check("snap_tdr0", 64'(last_rdata), 64'hFFFF_FFFF);
      cnt       = 64'h0000_0002_0000_0000;
      load_back = 1'b1;
      @(negedge sys_clk);
      load_back = 1'b0;
      bus_read(12'h008);
`ifdef TIMER_RF_SNAPSHOT_EN
      check("snap_tdr1_first", 64'(last_rdata), 64'h1);
`else
      check("snap_tdr1_first", 64'(last_rdata), 64'h2);
`endif
      bus_read(12'h008);
      check("snap_tdr1_second", 64'(last_rdata), 64'h2);

      // Reset mid-operation kills a pending cnt_clr pulse
      bus_write(12'h000, 32'h0000_0001, 4'h1);
      check("tcr_en_again", 64'(timer_en), 64'h1);
      bus_write(12'h000, 32'h0000_0000, 4'h1);
      check("cnt_clr_pulse2", 64'(cnt_clr), 64'h1);
      sys_rst_n = 1'b0;
      #1;
      check("async_rst_cnt_clr",  64'(cnt_clr), 64'h0);
      check("async_rst_div_val",  64'(div_val), 64'h1);
      check("async_rst_int_en",   64'(int_en), 64'h0);
      check("async_rst_halt_req", 64'(halt_req), 64'h0);
      check("async_rst_tcmp1",    TCMP[1*CNT_W +: CNT_W], 64'hFFFF_FFFF_FFFF_FFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
